// File: rtl/input_conditioner_pkg.sv
// Shared types and widths for the input conditioner and its button debouncers.
package input_conditioner_pkg;

  localparam int DATA_W  = 16;
  localparam int DEPTH_W = 4;

  // Per-button debounce state machine.
  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } btn_state_t;

endpackage

// File: rtl/input_conditioner_if.sv
// Bundle between the board-side buttons/switches, the conditioner and the
// downstream stack. The conditioner drives the stack through the master side.
interface input_conditioner_if;
  import input_conditioner_pkg::*;

  logic               btnRead;
  logic               btnWrite;
  logic [DATA_W-1:0]  sw;
  logic [DATA_W-1:0]  _input;
  logic               switchRead;
  logic               switchWrite;
  logic [DEPTH_W-1:0] depth;
  logic               full;
  logic               empty;
  logic               reject;

  modport master (
    input  btnRead, btnWrite, sw,
    output _input, switchRead, switchWrite, depth, full, empty, reject
  );

  modport slave (
    output btnRead, btnWrite, sw,
    input  _input, switchRead, switchWrite, depth, full, empty, reject
  );

endinterface

// File: rtl/input_conditioner_button_debounce.sv
// Two-flop synchronizer plus debounce FSM for one raw push button.
// confirm pulses for one cycle when a press has been stable long enough;
// holding the button never produces a second confirm.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic confirm
);
  import input_conditioner_pkg::*;

  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic             meta_reg;
  logic             sync_reg;
  btn_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic             confirm_reg, confirm_next;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= btn;
      sync_reg <= meta_reg;
    end
  end

  // Saturating increment of the stable-sample counter.
  assign cnt_inc = (cnt_reg == CNT_MAX) ? CNT_MAX : cnt_reg + 1'b1;

  // State, counter and confirm registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      confirm_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      confirm_reg <= confirm_next;
    end
  end

  // Next-state logic; the counter is cleared on every state change.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    confirm_next = 1'b0;
    unique case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (sync_reg) state_next = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!sync_reg) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_inc == CNT_MAX) begin
          state_next   = HELD;
          cnt_next     = '0;
          confirm_next = 1'b1;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      HELD: begin
        cnt_next = '0;
        if (!sync_reg) state_next = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (sync_reg) begin
          state_next = HELD;
          cnt_next   = '0;
        end else if (cnt_inc == CNT_MAX) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign confirm = confirm_reg;

endmodule

// File: rtl/input_conditioner.sv
// Turns two raw push buttons and a bank of switches into clean push/pop
// strobes for a downstream stack, tracking its occupancy so that pushes
// onto a full stack and pops from an empty one are refused. The stack is
// reset by the same reset net, so depth and the stack index stay aligned.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int MAX_DEPTH       = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input_conditioner_if.master  bus
);

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(MAX_DEPTH);

  logic [DATA_W-1:0]  sw_sync;
  logic               read_confirm, write_confirm;
  logic               pop_req, full_w, empty_w;
  logic               pop_pending_reg, pop_pending_next;
  logic [DEPTH_W-1:0] depth_reg, depth_next;
  logic [DATA_W-1:0]  data_reg, data_next;
  logic               push_reg, push_next;
  logic               pop_reg, pop_next;
  logic               reject_reg, reject_next;

  // Per-bit two-flop synchronizer for the data switches.
  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_sw_sync
      logic meta_reg;
      logic sync_reg;
      always_ff @(posedge clk) begin
        if (reset) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
        end else begin
          meta_reg <= bus.sw[gi];
          sync_reg <= meta_reg;
        end
      end
      assign sw_sync[gi] = sync_reg;
    end
  endgenerate

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_read_btn (
    .clk     (clk),
    .reset   (reset),
    .btn     (bus.btnRead),
    .confirm (read_confirm)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_write_btn (
    .clk     (clk),
    .reset   (reset),
    .btn     (bus.btnWrite),
    .confirm (write_confirm)
  );

  assign full_w  = (depth_reg == DEPTH_MAX);
  assign empty_w = (depth_reg == '0);

  // Arbitrate confirmed requests: a push wins a tie and the pop waits a cycle.
  always_comb begin
    depth_next       = depth_reg;
    data_next        = data_reg;
    push_next        = 1'b0;
    pop_next         = 1'b0;
    reject_next      = 1'b0;
    pop_pending_next = 1'b0;
    pop_req          = write_confirm | pop_pending_reg;

    if (read_confirm) begin
      data_next = sw_sync;
      if (full_w) begin
        reject_next = 1'b1;
      end else begin
        push_next  = 1'b1;
        depth_next = depth_reg + 1'b1;
      end
    end

    if (pop_req) begin
      if (push_next) begin
        pop_pending_next = 1'b1;
      end else if (empty_w) begin
        reject_next = 1'b1;
      end else begin
        pop_next   = 1'b1;
        depth_next = depth_reg - 1'b1;
      end
    end
  end

  // Registered strobes, data word and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      depth_reg       <= '0;
      data_reg        <= '0;
      push_reg        <= 1'b0;
      pop_reg         <= 1'b0;
      reject_reg      <= 1'b0;
      pop_pending_reg <= 1'b0;
    end else begin
      depth_reg       <= depth_next;
      data_reg        <= data_next;
      push_reg        <= push_next;
      pop_reg         <= pop_next;
      reject_reg      <= reject_next;
      pop_pending_reg <= pop_pending_next;
    end
  end

  assign bus._input      = data_reg;
  assign bus.switchRead  = push_reg;
  assign bus.switchWrite = pop_reg;
  assign bus.depth       = depth_reg;
  assign bus.full        = full_w;
  assign bus.empty       = empty_w;
  assign bus.reject      = reject_reg;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with a short debounce window.
// A clean press driven just before edge E0 reaches the strobe after E7:
// 2 synchronizer edges, 1 IDLE detect, 4 stable samples, 1 capture edge.
`timescale 1ns/1ps
module tb_input_conditioner;
  import input_conditioner_pkg::*;

  localparam int DC  = 4;
  localparam int MD  = 15;
  localparam int LAT = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;

  int n_asserts = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int rd_cnt    = 0;
  int wr_cnt    = 0;
  int rej_cnt   = 0;
  int rd_cyc    = 0;
  int wr_cyc    = 0;
  logic [15:0] rd_data = '0;

  int t0, rd0, wr0, rej0;

  input_conditioner_if bus();

  input_conditioner #(.DEBOUNCE_CYCLES(DC), .MAX_DEPTH(MD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample the outputs 3ns after the edge.
  task automatic step();
    @(posedge clk);
    #3;
    cyc++;
    if (bus.switchRead === 1'b1) begin
      rd_cnt++;
      rd_cyc  = cyc;
      rd_data = bus._input;
      $display("cycle %0d push  data=%h depth=%0d", cyc, bus._input, bus.depth);
    end
    if (bus.switchWrite === 1'b1) begin
      wr_cnt++;
      wr_cyc = cyc;
      $display("cycle %0d pop   depth=%0d", cyc, bus.depth);
    end
    if (bus.reject === 1'b1) begin
      rej_cnt++;
      $display("cycle %0d reject depth=%0d", cyc, bus.depth);
    end
    chk("strobe_exclusive", {31'd0, bus.switchRead & bus.switchWrite}, 32'd0);
  endtask

  task automatic press(input logic rd, input logic wr, input logic [15:0] val, input int hold);
    bus.sw = val;
    if (rd) bus.btnRead = 1'b1;
    if (wr) bus.btnWrite = 1'b1;
    repeat (hold) step();
    bus.btnRead  = 1'b0;
    bus.btnWrite = 1'b0;
    repeat (12) step();
  endtask

  initial begin
    bus.btnRead  = 1'b0;
    bus.btnWrite = 1'b0;
    bus.sw       = '0;
    reset        = 1'b1;
    repeat (4) step();

    // Reset state
    chk("rst_input", {16'd0, bus._input}, 32'd0);
    chk("rst_depth", {28'd0, bus.depth}, 32'd0);
    chk("rst_full", {31'd0, bus.full}, 32'd0);
    chk("rst_empty", {31'd0, bus.empty}, 32'd1);
    chk("rst_switchRead", {31'd0, bus.switchRead}, 32'd0);
    chk("rst_switchWrite", {31'd0, bus.switchWrite}, 32'd0);
    chk("rst_reject", {31'd0, bus.reject}, 32'd0);
    reset = 1'b0;
    repeat (2) step();

    // Pop from empty is refused
    wr0 = wr_cnt; rej0 = rej_cnt;
    press(1'b0, 1'b1, 16'h0000, 12);
    chk("pop_empty_no_strobe", wr_cnt - wr0, 32'd0);
    chk("pop_empty_reject", rej_cnt - rej0, 32'd1);
    chk("pop_empty_depth", {28'd0, bus.depth}, 32'd0);

    // Long hold gives exactly one push
    t0 = cyc; rd0 = rd_cnt;
    press(1'b1, 1'b0, 16'hA5A5, 20);
    chk("hold_one_push", rd_cnt - rd0, 32'd1);
    chk("hold_data", {16'd0, rd_data}, 32'h0000A5A5);
    chk("hold_latency", rd_cyc - t0, LAT);
    chk("hold_depth", {28'd0, bus.depth}, 32'd1);
    chk("hold_input_kept", {16'd0, bus._input}, 32'h0000A5A5);
    chk("hold_not_empty", {31'd0, bus.empty}, 32'd0);

    // Bouncing press: 1,0,1,0 then stable 1
    rd0 = rd_cnt;
    bus.sw = 16'h3C3C;
    bus.btnRead = 1'b1; step();
    bus.btnRead = 1'b0; step();
    bus.btnRead = 1'b1; step();
    bus.btnRead = 1'b0; step();
    t0 = cyc;
    bus.btnRead = 1'b1;
    repeat (14) step();
    bus.btnRead = 1'b0;
    repeat (12) step();
    chk("bounce_one_push", rd_cnt - rd0, 32'd1);
    chk("bounce_latency", rd_cyc - t0, LAT);
    chk("bounce_data", {16'd0, rd_data}, 32'h00003C3C);
    chk("bounce_depth", {28'd0, bus.depth}, 32'd2);

    // Reset during PRESS_WAIT at depth 5, button still held afterwards
    press(1'b1, 1'b0, 16'h1111, 12);
    press(1'b1, 1'b0, 16'h2222, 12);
    press(1'b1, 1'b0, 16'h3333, 12);
    chk("pre_reset_depth", {28'd0, bus.depth}, 32'd5);
    rd0 = rd_cnt;
    bus.sw = 16'h4444;
    bus.btnRead = 1'b1;
    repeat (4) step();
    reset = 1'b1;
    repeat (3) step();
    chk("midpress_rst_no_push", rd_cnt - rd0, 32'd0);
    chk("midpress_rst_depth", {28'd0, bus.depth}, 32'd0);
    chk("midpress_rst_input", {16'd0, bus._input}, 32'd0);
    t0 = cyc;
    reset = 1'b0;
    repeat (14) step();
    bus.btnRead = 1'b0;
    repeat (12) step();
    chk("after_rst_one_push", rd_cnt - rd0, 32'd1);
    chk("after_rst_latency", rd_cyc - t0, LAT);
    chk("after_rst_depth", {28'd0, bus.depth}, 32'd1);
    chk("after_rst_data", {16'd0, rd_data}, 32'h00004444);

    // Simultaneous push and pop at depth 3
    press(1'b1, 1'b0, 16'h5555, 12);
    press(1'b1, 1'b0, 16'h6666, 12);
    chk("pre_tie_depth", {28'd0, bus.depth}, 32'd3);
    rd0 = rd_cnt; wr0 = wr_cnt; rej0 = rej_cnt;
    press(1'b1, 1'b1, 16'h7777, 14);
    chk("tie_push", rd_cnt - rd0, 32'd1);
    chk("tie_pop", wr_cnt - wr0, 32'd1);
    chk("tie_pop_next_cycle", wr_cyc - rd_cyc, 32'd1);
    chk("tie_depth", {28'd0, bus.depth}, 32'd3);
    chk("tie_no_reject", rej_cnt - rej0, 32'd0);

    // Fill to full from reset, then one more push
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    step();
    rd0 = rd_cnt; rej0 = rej_cnt;
    for (int i = 0; i < 16; i++) begin
      press(1'b1, 1'b0, 16'h0100 + 16'(i), 12);
    end
    chk("fill_pushes", rd_cnt - rd0, 32'd15);
    chk("fill_depth", {28'd0, bus.depth}, 32'd15);
    chk("fill_full", {31'd0, bus.full}, 32'd1);
    chk("fill_reject", rej_cnt - rej0, 32'd1);
    chk("fill_last_push_data", {16'd0, rd_data}, 32'h0000010E);
    chk("fill_input_updated", {16'd0, bus._input}, 32'h0000010F);

    // Pop from full
    wr0 = wr_cnt;
    press(1'b0, 1'b1, 16'h0000, 12);
    chk("pop_full_strobe", wr_cnt - wr0, 32'd1);
    chk("pop_full_depth", {28'd0, bus.depth}, 32'd14);
    chk("pop_full_not_full", {31'd0, bus.full}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
